// File: rtl/sh7604_dbus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sh7604_dbus_arbiter                                        |
// | Description : DBUS arbiter for CPU/cache, DMAC ch0 and DMAC ch1 with     |
// |               locked sequences and a CPU starvation guard.               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sh7604_dbus_arbiter #(
    parameter int DMA_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             RES_N,
    input  logic             RR_MODE,
    input  logic [2:0][31:0] M_A,
    input  logic [2:0][31:0] M_DO,
    input  logic [2:0][3:0]  M_BA,
    input  logic [2:0]       M_WE,
    input  logic [2:0]       M_REQ,
    input  logic [2:0]       M_LOCK,
    output logic [31:0]      M_DI,
    output logic [2:0]       M_WAIT,
    output logic [31:0]      DBUS_A,
    output logic [31:0]      DBUS_DO,
    output logic [3:0]       DBUS_BA,
    output logic             DBUS_WE,
    output logic             DBUS_REQ,
    output logic             DBUS_LOCK,
    input  logic [31:0]      DBUS_DI,
    input  logic             DBUS_WAIT,
    output logic [1:0]       OWNER
);

    localparam int               c_BCW       = (DMA_BURST < 1) ? 1 : $clog2(DMA_BURST + 1);
    localparam logic [c_BCW-1:0] c_BURST_MAX = c_BCW'(DMA_BURST);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_LOCK  = 2'd2;
    localparam logic [1:0] c_NONE     = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic             r_rr;          // 0: ch0 is favoured next, 1: ch1
    logic             w_rr_nxt;
    logic [c_BCW-1:0] r_burst;
    logic [c_BCW-1:0] w_burst_nxt;

    logic             w_own_req;
    logic             w_own_lock;
    logic [1:0]       w_dma_pick;
    logic             w_cpu_win;
    logic [1:0]       w_winner;

    // State register: async power-on reset, soft reset only on enabled cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_ST_IDLE;
            r_owner <= c_NONE;
            r_rr    <= 1'b0;
            r_burst <= '0;
        end else if (CE_R) begin
            if (!RES_N) begin
                r_state <= c_ST_IDLE;
                r_owner <= c_NONE;
                r_rr    <= 1'b0;
                r_burst <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_rr    <= w_rr_nxt;
                r_burst <= w_burst_nxt;
            end
        end
    end

    // Arbitration and next-state logic
    always_comb begin
        w_dma_pick = 2'd1;
        if (M_REQ[1] && M_REQ[2]) begin
            w_dma_pick = (RR_MODE && r_rr) ? 2'd2 : 2'd1;
        end else if (M_REQ[2]) begin
            w_dma_pick = 2'd2;
        end
        w_cpu_win = M_REQ[0] && (!(M_REQ[1] || M_REQ[2]) || (r_burst >= c_BURST_MAX));
        w_winner  = w_cpu_win ? 2'd0 : w_dma_pick;

        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_burst_nxt = M_REQ[0] ? r_burst : '0;

        case (r_state)
            c_ST_IDLE: begin
                if (|M_REQ) begin
                    w_state_nxt = c_ST_GRANT;
                    w_owner_nxt = w_winner;
                    if (w_cpu_win) begin
                        w_burst_nxt = '0;
                    end else begin
                        if (M_REQ[0]) begin
                            w_burst_nxt = r_burst + c_BCW'(1);
                        end
                        if (RR_MODE) begin
                            w_rr_nxt = (w_winner == 2'd1);
                        end
                    end
                end
            end
            c_ST_GRANT: begin
                // Owner withdrawing its request is an abort, even if locked
                if (!w_own_req) begin
                    w_state_nxt = c_ST_IDLE;
                    w_owner_nxt = c_NONE;
                end else if (!DBUS_WAIT) begin
                    if (w_own_lock) begin
                        w_state_nxt = c_ST_LOCK;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_owner_nxt = c_NONE;
                    end
                end
            end
            c_ST_LOCK: begin
                if (w_own_req) begin
                    w_state_nxt = c_ST_GRANT;
                end else if (!w_own_lock) begin
                    w_state_nxt = c_ST_IDLE;
                    w_owner_nxt = c_NONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_owner_nxt = c_NONE;
            end
        endcase
    end

    // Output mux: owner's fields onto DBUS, zero when nobody owns the bus
    always_comb begin
        DBUS_A     = '0;
        DBUS_DO    = '0;
        DBUS_BA    = '0;
        DBUS_WE    = 1'b0;
        w_own_req  = 1'b0;
        w_own_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (r_owner == 2'(i)) begin
                DBUS_A     = M_A[i];
                DBUS_DO    = M_DO[i];
                DBUS_BA    = M_BA[i];
                DBUS_WE    = M_WE[i];
                w_own_req  = M_REQ[i];
                w_own_lock = M_LOCK[i];
            end
        end
        DBUS_REQ  = (r_state == c_ST_GRANT) && w_own_req;
        DBUS_LOCK = w_own_lock;

        M_WAIT = M_REQ;
        for (int i = 0; i < 3; i++) begin
            if ((r_owner == 2'(i)) && (r_state == c_ST_GRANT) && !DBUS_WAIT) begin
                M_WAIT[i] = 1'b0;
            end
        end
    end

    assign M_DI  = DBUS_DI;
    assign OWNER = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_sh7604_dbus_arbiter.sv
`timescale 1ns/1ps
// Bench for sh7604_dbus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_sh7604_dbus_arbiter;

    localparam int DMA_BURST = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             CE_R;
    logic             RES_N;
    logic             RR_MODE;
    logic [2:0][31:0] M_A;
    logic [2:0][31:0] M_DO;
    logic [2:0][3:0]  M_BA;
    logic [2:0]       M_WE;
    logic [2:0]       M_REQ;
    logic [2:0]       M_LOCK;
    logic [31:0]      M_DI;
    logic [2:0]       M_WAIT;
    logic [31:0]      DBUS_A;
    logic [31:0]      DBUS_DO;
    logic [3:0]       DBUS_BA;
    logic             DBUS_WE;
    logic             DBUS_REQ;
    logic             DBUS_LOCK;
    logic [31:0]      DBUS_DI;
    logic             DBUS_WAIT;
    logic [1:0]       OWNER;

    int total = 0;
    int bad   = 0;
    int gseq[16];
    int gcnt;

    always #5 CLK = ~CLK;

    sh7604_dbus_arbiter #(.DMA_BURST(DMA_BURST)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N), .RR_MODE(RR_MODE),
        .M_A(M_A), .M_DO(M_DO), .M_BA(M_BA), .M_WE(M_WE), .M_REQ(M_REQ), .M_LOCK(M_LOCK),
        .M_DI(M_DI), .M_WAIT(M_WAIT),
        .DBUS_A(DBUS_A), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA), .DBUS_WE(DBUS_WE),
        .DBUS_REQ(DBUS_REQ), .DBUS_LOCK(DBUS_LOCK), .DBUS_DI(DBUS_DI), .DBUS_WAIT(DBUS_WAIT),
        .OWNER(OWNER)
    );

    task automatic set_idle_inputs();
        CE_R = 1'b1; RES_N = 1'b1; RR_MODE = 1'b0;
        M_REQ = '0; M_LOCK = '0; M_WE = '0;
        DBUS_WAIT = 1'b0; DBUS_DI = '0;
        for (int i = 0; i < 3; i++) begin
            M_A[i]  = 32'hA000_0000 + 32'(i);
            M_DO[i] = 32'hD000_0000 + 32'(i);
            M_BA[i] = 4'hF;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        set_idle_inputs();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Records the owner at the start of each fresh grant, bounded in cycles.
    task automatic collect_grants(input int n);
        logic [1:0] prev;
        prev = 2'd3;
        gcnt = 0;
        for (int c = 0; c < 200 && gcnt < n; c++) begin
            @(negedge CLK); #1;
            if (OWNER != 2'd3 && prev == 2'd3) begin
                gseq[gcnt] = int'(OWNER);
                gcnt++;
            end
            prev = OWNER;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        set_idle_inputs();
        M_REQ = 3'b101;
        #1;
        total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL rst_owner: got %0d want 3", OWNER); end
        total++; if (DBUS_REQ !== 1'b0) begin bad++; $display("FAIL rst_dbus_req: got %b want 0", DBUS_REQ); end
        total++; if ({DBUS_A, DBUS_DO, DBUS_BA, DBUS_WE, DBUS_LOCK} !== 70'd0) begin
            bad++; $display("FAIL rst_dbus_fields: A=%h DO=%h BA=%h WE=%b LOCK=%b want all 0", DBUS_A, DBUS_DO, DBUS_BA, DBUS_WE, DBUS_LOCK);
        end
        total++; if (M_WAIT !== 3'b101) begin bad++; $display("FAIL rst_wait: got %b want 101", M_WAIT); end
        // soft reset: ignored without CE_R, effective with it
        @(negedge CLK);
        RST_N = 1'b1;
        M_REQ = 3'b001; DBUS_WAIT = 1'b1;
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL soft_pre_owner: got %0d want 0", OWNER); end
        CE_R = 1'b0; RES_N = 1'b0;
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL soft_no_ce: got %0d want 0", OWNER); end
        CE_R = 1'b1;
        @(negedge CLK);
        RES_N = 1'b1; M_REQ = '0;
        #1;
        total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL soft_owner: got %0d want 3", OWNER); end
        total++; if (DBUS_REQ !== 1'b0) begin bad++; $display("FAIL soft_dbus_req: got %b want 0", DBUS_REQ); end
    endtask

    task automatic test_cpu_wait();
        do_reset();
        M_REQ[0] = 1'b1; M_WE[0] = 1'b0; M_A[0] = 32'h0600_1234; DBUS_WAIT = 1'b1;
        #1;
        total++; if (M_WAIT !== 3'b001) begin bad++; $display("FAIL cpu_idle_wait: got %b want 001", M_WAIT); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL cpu_owner: got %0d want 0", OWNER); end
        total++; if (DBUS_REQ !== 1'b1) begin bad++; $display("FAIL cpu_dbus_req: got %b want 1", DBUS_REQ); end
        total++; if (DBUS_A !== 32'h0600_1234) begin bad++; $display("FAIL cpu_addr: got %h want 06001234", DBUS_A); end
        total++; if (M_WAIT[0] !== 1'b1) begin bad++; $display("FAIL cpu_wait1: got %b want 1", M_WAIT[0]); end
        @(negedge CLK); #1;
        total++; if (M_WAIT[0] !== 1'b1) begin bad++; $display("FAIL cpu_wait2: got %b want 1", M_WAIT[0]); end
        DBUS_WAIT = 1'b0; DBUS_DI = 32'hCAFE_F00D;
        #1;
        total++; if (M_WAIT[0] !== 1'b0) begin bad++; $display("FAIL cpu_wait3: got %b want 0", M_WAIT[0]); end
        total++; if (M_DI !== 32'hCAFE_F00D) begin bad++; $display("FAIL cpu_rdata: got %h want cafef00d", M_DI); end
        @(negedge CLK);
        M_REQ = '0;
        #1;
        total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL cpu_release: got %0d want 3", OWNER); end
    endtask

    task automatic test_round_robin();
        int exp_rr[4];
        exp_rr = '{1, 2, 1, 2};
        do_reset();
        RR_MODE = 1'b1; M_REQ = 3'b110;
        collect_grants(4);
        total++; if (gcnt != 4) begin bad++; $display("FAIL rr_timeout: got %0d grants want 4", gcnt); end
        for (int k = 0; k < gcnt; k++) begin
            total++; if (gseq[k] != exp_rr[k]) begin bad++; $display("FAIL rr_seq[%0d]: got %0d want %0d", k, gseq[k], exp_rr[k]); end
        end
        do_reset();
        RR_MODE = 1'b0; M_REQ = 3'b110;
        collect_grants(4);
        total++; if (gcnt != 4) begin bad++; $display("FAIL fixed_timeout: got %0d grants want 4", gcnt); end
        for (int k = 0; k < gcnt; k++) begin
            total++; if (gseq[k] != 1) begin bad++; $display("FAIL fixed_seq[%0d]: got %0d want 1", k, gseq[k]); end
        end
    endtask

    task automatic test_burst_guard();
        int exp_b[10];
        exp_b = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        M_REQ = 3'b011;
        collect_grants(10);
        total++; if (gcnt != 10) begin bad++; $display("FAIL burst_timeout: got %0d grants want 10", gcnt); end
        for (int k = 0; k < gcnt; k++) begin
            total++; if (gseq[k] != exp_b[k]) begin bad++; $display("FAIL burst_seq[%0d]: got %0d want %0d", k, gseq[k], exp_b[k]); end
        end
    endtask

    task automatic test_tas();
        do_reset();
        M_REQ[0] = 1'b1; M_LOCK[0] = 1'b1; M_WE[0] = 1'b0; M_A[0] = 32'h0000_0100;
        @(negedge CLK);
        M_REQ[1] = 1'b1;
        #1;
        total++; if (OWNER !== 2'd0 || DBUS_LOCK !== 1'b1) begin bad++; $display("FAIL tas_read: owner=%0d lock=%b want 0/1", OWNER, DBUS_LOCK); end
        total++; if (M_WAIT !== 3'b010) begin bad++; $display("FAIL tas_read_wait: got %b want 010", M_WAIT); end
        @(negedge CLK);
        M_WE[0] = 1'b1; M_LOCK[0] = 1'b0; M_DO[0] = 32'h0000_0080;
        #1;
        total++; if (OWNER !== 2'd0 || DBUS_REQ !== 1'b0) begin bad++; $display("FAIL tas_hold: owner=%0d req=%b want 0/0", OWNER, DBUS_REQ); end
        total++; if (M_WAIT !== 3'b011) begin bad++; $display("FAIL tas_hold_wait: got %b want 011", M_WAIT); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0 || DBUS_WE !== 1'b1 || DBUS_REQ !== 1'b1) begin
            bad++; $display("FAIL tas_write: owner=%0d we=%b req=%b want 0/1/1", OWNER, DBUS_WE, DBUS_REQ);
        end
        total++; if (M_WAIT !== 3'b010) begin bad++; $display("FAIL tas_write_wait: got %b want 010", M_WAIT); end
        @(negedge CLK);
        M_REQ[0] = 1'b0;
        #1;
        total++; if (OWNER !== 2'd3 || M_WAIT[1] !== 1'b1) begin bad++; $display("FAIL tas_idle: owner=%0d wait1=%b want 3/1", OWNER, M_WAIT[1]); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd1 || M_WAIT[1] !== 1'b0) begin bad++; $display("FAIL tas_dma: owner=%0d wait1=%b want 1/0", OWNER, M_WAIT[1]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        M_REQ[0] = 1'b1; DBUS_WAIT = 1'b1;
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0 || DBUS_REQ !== 1'b1) begin bad++; $display("FAIL arst_pre: owner=%0d req=%b want 0/1", OWNER, DBUS_REQ); end
        #2;
        RST_N = 1'b0;
        #1;
        total++; if (OWNER !== 2'd3 || DBUS_REQ !== 1'b0) begin bad++; $display("FAIL arst_now: owner=%0d req=%b want 3/0", OWNER, DBUS_REQ); end
        @(negedge CLK);
        RST_N = 1'b1; DBUS_WAIT = 1'b0;
        #1;
        total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL arst_idle: got %0d want 3", OWNER); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL arst_regrant: got %0d want 0", OWNER); end
    endtask

    task automatic test_abort();
        do_reset();
        M_REQ[0] = 1'b1; DBUS_WAIT = 1'b1;
        @(negedge CLK);
        M_REQ[2] = 1'b1;
        #1;
        total++; if (OWNER !== 2'd0) begin bad++; $display("FAIL abort_pre: got %0d want 0", OWNER); end
        @(negedge CLK);
        M_REQ[0] = 1'b0;
        #1;
        total++; if (DBUS_REQ !== 1'b0 || M_WAIT[2] !== 1'b1) begin bad++; $display("FAIL abort_drop: req=%b wait2=%b want 0/1", DBUS_REQ, M_WAIT[2]); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd3) begin bad++; $display("FAIL abort_idle: got %0d want 3", OWNER); end
        @(negedge CLK); #1;
        total++; if (OWNER !== 2'd2 || DBUS_REQ !== 1'b1) begin bad++; $display("FAIL abort_ch1: owner=%0d req=%b want 2/1", OWNER, DBUS_REQ); end
    endtask

    // Random traffic against a transaction-level model of who holds the bus.
    task automatic test_random();
        int         m_owner;    // -1 when bus is free
        bit         m_active;   // owner is presenting an access (vs holding a lock)
        int         m_next_ch;  // DMA channel favoured under round-robin
        int         m_dma_run;  // DMA grants since the CPU last got the bus
        bit         done[3];
        bit         was_lock[3];
        logic [1:0] exp_owner;
        logic       exp_req;
        logic       exp_lock;
        logic [31:0] exp_a;
        logic [2:0] exp_wait;
        int         win;
        do_reset();
        m_owner = -1; m_active = 0; m_next_ch = 0; m_dma_run = 0;
        for (int i = 0; i < 3; i++) begin done[i] = 0; was_lock[i] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    if (was_lock[i] && $urandom_range(0, 3) != 0) begin
                        M_A[i] = $urandom; M_DO[i] = $urandom; M_WE[i] = 1'b1; M_LOCK[i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        M_A[i] = $urandom; M_DO[i] = $urandom; M_BA[i] = 4'($urandom);
                        M_WE[i] = 1'($urandom); M_LOCK[i] = ($urandom_range(0, 5) == 0);
                    end else begin
                        M_REQ[i] = 1'b0; M_LOCK[i] = 1'b0;
                    end
                end else if (M_REQ[i]) begin
                    if ($urandom_range(0, 49) == 0) begin M_REQ[i] = 1'b0; M_LOCK[i] = 1'b0; end
                end else if ($urandom_range(0, 2) == 0) begin
                    M_REQ[i] = 1'b1; M_A[i] = $urandom; M_DO[i] = $urandom; M_BA[i] = 4'($urandom);
                    M_WE[i] = 1'($urandom); M_LOCK[i] = ($urandom_range(0, 5) == 0);
                end
            end
            if (cyc % 500 == 0) RR_MODE = 1'($urandom_range(0, 1));
            CE_R      = ($urandom_range(0, 3) != 0);
            RES_N     = ($urandom_range(0, 199) != 0);
            DBUS_WAIT = ($urandom_range(0, 2) == 0);
            DBUS_DI   = $urandom;
            #1;
            exp_owner = 2'd3; exp_req = 1'b0; exp_lock = 1'b0; exp_a = '0;
            if (m_owner >= 0) begin
                exp_owner = 2'(m_owner);
                exp_req   = m_active && M_REQ[m_owner];
                exp_lock  = M_LOCK[m_owner];
                exp_a     = M_A[m_owner];
            end
            for (int i = 0; i < 3; i++) exp_wait[i] = M_REQ[i] && !(m_owner == i && m_active && !DBUS_WAIT);
            total++; if (OWNER !== exp_owner) begin bad++; $display("FAIL rnd_owner @%0d: got %0d want %0d", cyc, OWNER, exp_owner); end
            total++; if (DBUS_REQ !== exp_req) begin bad++; $display("FAIL rnd_req @%0d: got %b want %b", cyc, DBUS_REQ, exp_req); end
            total++; if (DBUS_LOCK !== exp_lock) begin bad++; $display("FAIL rnd_lock @%0d: got %b want %b", cyc, DBUS_LOCK, exp_lock); end
            total++; if (DBUS_A !== exp_a) begin bad++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, DBUS_A, exp_a); end
            total++; if (M_WAIT !== exp_wait) begin bad++; $display("FAIL rnd_wait @%0d: got %b want %b", cyc, M_WAIT, exp_wait); end
            total++; if (M_DI !== DBUS_DI) begin bad++; $display("FAIL rnd_rdata @%0d: got %h want %h", cyc, M_DI, DBUS_DI); end
            for (int i = 0; i < 3; i++) begin
                done[i]     = CE_R && M_REQ[i] && !exp_wait[i];
                was_lock[i] = M_LOCK[i];
            end
            if (CE_R) begin
                if (!RES_N) begin
                    m_owner = -1; m_active = 0; m_next_ch = 0; m_dma_run = 0;
                end else begin
                    if (!M_REQ[0]) m_dma_run = 0;
                    if (m_owner < 0) begin
                        if (M_REQ != 3'b000) begin
                            if (M_REQ[0] && (M_REQ[2:1] == 2'b00 || m_dma_run >= DMA_BURST)) win = 0;
                            else if (M_REQ[1] && M_REQ[2]) win = (RR_MODE && m_next_ch == 1) ? 2 : 1;
                            else win = M_REQ[1] ? 1 : 2;
                            m_owner = win; m_active = 1;
                            if (win == 0) m_dma_run = 0;
                            else begin
                                if (M_REQ[0]) m_dma_run = m_dma_run + 1;
                                if (RR_MODE) m_next_ch = (win == 1) ? 1 : 0;
                            end
                        end
                    end else if (m_active) begin
                        if (!M_REQ[m_owner]) m_owner = -1;
                        else if (!DBUS_WAIT) begin
                            if (M_LOCK[m_owner]) m_active = 0;
                            else m_owner = -1;
                        end
                    end else begin
                        if (M_REQ[m_owner]) m_active = 1;
                        else if (!M_LOCK[m_owner]) m_owner = -1;
                    end
                end
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        set_idle_inputs();
        test_reset();
        test_cpu_wait();
        test_round_robin();
        test_burst_guard();
        test_tas();
        test_async_reset();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
